// File: rtl/npu_cube_add_acc_if.sv
// Beat/result bundle for npu_cube_add_acc: carry-save input beat plus accumulated result handshake.
interface npu_cube_add_acc_if #(
  parameter int unsigned DWB = 8,
  parameter int unsigned DWS = 21
);
  logic [DWB+3:0] l4_linecay0;
  logic [DWB+5:0] l4_linesum0;
  logic [DWB+1:0] l4_linecay1;
  logic [DWB+3:0] l4_linesum1;
  logic [DWB+1:0] l4_linecay2;
  logic [DWB+3:0] l4_linesum2;
  logic [DWB+1:0] l4_linecay3;
  logic [DWB+3:0] l4_linesum3;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [DWS-1:0] out_data;
  logic [7:0]     out_cnt;
  logic           out_ovf;

  modport master (
    output l4_linecay0, l4_linesum0, l4_linecay1, l4_linesum1,
    output l4_linecay2, l4_linesum2, l4_linecay3, l4_linesum3,
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_ovf
  );

  modport slave (
    input  l4_linecay0, l4_linesum0, l4_linecay1, l4_linesum1,
    input  l4_linecay2, l4_linesum2, l4_linecay3, l4_linesum3,
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_ovf
  );
endinterface

// File: rtl/npu_cube_add_acc.sv
// Two-stage carry-save resolve + group accumulator with output hold.
// Optional macro NPU_CUBE_ACC_SAT_EN: clamp accumulator on overflow instead of wrapping.
module npu_cube_add_acc #(
  parameter int unsigned DWB       = 8,
  parameter int unsigned DWPRODUCT = 19,
  parameter int unsigned DWS       = 21
) (
  input logic               clk,
  input logic               rst_n,
  npu_cube_add_acc_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e               state_q, state_d;
  logic [DWS-1:0]       acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic [DWPRODUCT-1:0] s1_p_q, s1_p_d;
  logic [DWPRODUCT-1:0] p_comb;
  logic [DWS:0]         add_sum;
  logic                 in_ready;
  logic                 in_fire;
  logic                 hold;
  logic                 do_start;
  logic                 do_add;
  logic                 s1_take;

  // Operands are truncated before summing; identical modulo 2^DWPRODUCT to a wide sum.
  always_comb begin
    p_comb = DWPRODUCT'(bus.l4_linesum0)
           + (DWPRODUCT'(bus.l4_linecay0) << 1)
           + (DWPRODUCT'(bus.l4_linesum1) << 2)
           + (DWPRODUCT'(bus.l4_linecay1) << 3)
           + (DWPRODUCT'(bus.l4_linesum2) << 4)
           + (DWPRODUCT'(bus.l4_linecay2) << 5)
           + (DWPRODUCT'(bus.l4_linesum3) << 6)
           + (DWPRODUCT'(bus.l4_linecay3) << 7);
  end

  assign hold     = (state_q == StHold);
  assign in_ready = !s1_valid_q || !hold || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_p_d     = s1_p_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_last_d  = bus.in_last;
      s1_p_d     = p_comb;
    end else if (s1_take) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    do_start = 1'b0;
    do_add   = 1'b0;
    add_sum  = {1'b0, acc_q} + (DWS+1)'(s1_p_q);

    unique case (state_q)
      StIdle: do_start = s1_valid_q;
      StAcc:  do_add   = s1_valid_q;
      StHold: begin
        // Handoff and the next group's first beat share one cycle: no bubble.
        if (bus.out_ready) begin
          state_d  = StIdle;
          ovf_d    = 1'b0;
          do_start = s1_valid_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_start) begin
      acc_d = DWS'(s1_p_q);
      cnt_d = 8'd1;
      ovf_d = 1'b0;
    end

    if (do_add) begin
      ovf_d = ovf_q | add_sum[DWS];
      cnt_d = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
`ifdef NPU_CUBE_ACC_SAT_EN
      acc_d = add_sum[DWS] ? {DWS{1'b1}} : add_sum[DWS-1:0];
`else
      acc_d = add_sum[DWS-1:0];
`endif
    end

    if (do_start || do_add) begin
      state_d = s1_last_q ? StHold : StAcc;
    end
  end

  assign s1_take = do_start || do_add;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_p_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_p_q     <= s1_p_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = hold;
  assign bus.out_data  = hold ? acc_q : '0;
  assign bus.out_cnt   = hold ? cnt_q : '0;
  assign bus.out_ovf   = hold ? ovf_q : 1'b0;

endmodule
